// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types, segment table and select helpers for the scan decoder
package seg_pkg;

   // Scan FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   // All digit selects inactive (active-low bus)
   localparam logic [3:0] SEL_BLANK = 4'b1111;

   // Active-low g..a pattern for each hex nibble; entry i decodes to nibble i
   localparam logic [15:0][6:0] SEG_TABLE = '{
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   // A select is legal when exactly one active-low bit is driven low
   function automatic logic sel_is_legal(input logic [3:0] sel);
      return $onehot(~sel);
   endfunction

   // Position of the low bit in a legal active-low one-hot select
   function automatic logic [1:0] sel_index(input logic [3:0] sel);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!sel[i]) begin
            idx = 2'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - combinational seven-segment pattern to nibble lookup
module seg_pattern_decode
   import seg_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       match
);

   // Search the table; nibble stays 0 when no entry matches
   always_comb begin
      nibble = 4'h0;
      match  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (pattern == SEG_TABLE[i]) begin
            nibble = 4'(i);
            match  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers a 4-digit hex value from a multiplexed 7-seg scan
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  HEX,
   input  logic [3:0]  HEX_DIGIT,
   output logic [15:0] value,
   output logic [3:0]  dp,
   output logic        valid,
   output logic        frame_done,
   output logic        err,
   output logic        stall
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
   localparam logic [TW-1:0] TMO_MAX     = TW'(TIMEOUT);

   state_t        state_q,      state_d;
   logic [3:0]    cur_sel_q,    cur_sel_d;
   logic [SW-1:0] settle_cnt_q, settle_cnt_d;
   logic [7:0]    hex_prev_q,   hex_prev_d;
   logic [3:0]    seen_q,       seen_d;
   logic [15:0]   slot_nib_q,   slot_nib_d;
   logic [3:0]    slot_dp_q,    slot_dp_d;
   logic [15:0]   value_q,      value_d;
   logic [3:0]    dp_q,         dp_d;
   logic          valid_q,      valid_d;
   logic          frame_done_q, frame_done_d;
   logic          err_q,        err_d;
   logic [TW-1:0] tmo_cnt_q,    tmo_cnt_d;
   logic          stall_q,      stall_d;

   logic [3:0] dec_nibble;
   logic       dec_match;
   logic [1:0] cur_idx;
   logic       sel_legal;
   logic       sel_blank;
   logic       sel_illegal;
   logic       commit;

   seg_pattern_decode u_decode (
      .pattern (HEX[6:0]),
      .nibble  (dec_nibble),
      .match   (dec_match)
   );

   assign cur_idx     = sel_index(cur_sel_q);
   assign sel_legal   = sel_is_legal(HEX_DIGIT);
   assign sel_blank   = (HEX_DIGIT == SEL_BLANK);
   assign sel_illegal = !sel_legal && !sel_blank;
   assign commit      = (seen_q == 4'hF);

   // Next-state logic: scan FSM, slot capture, frame commit and timeout
   always_comb begin
      state_d      = state_q;
      cur_sel_d    = cur_sel_q;
      settle_cnt_d = settle_cnt_q;
      hex_prev_d   = HEX;
      seen_d       = seen_q;
      slot_nib_d   = slot_nib_q;
      slot_dp_d    = slot_dp_q;
      value_d      = value_q;
      dp_d         = dp_q;
      valid_d      = valid_q;
      frame_done_d = 1'b0;
      err_d        = 1'b0;

      // A full set of slots is published one cycle after the last capture
      if (commit) begin
         value_d      = slot_nib_q;
         dp_d         = slot_dp_q;
         valid_d      = 1'b1;
         frame_done_d = 1'b1;
         seen_d       = 4'h0;
      end

      if (sel_illegal) begin
         err_d        = 1'b1;
         seen_d       = 4'h0;
         settle_cnt_d = '0;
         state_d      = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sel_legal) begin
                  cur_sel_d    = HEX_DIGIT;
                  settle_cnt_d = '0;
                  state_d      = ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (sel_blank) begin
                  state_d = ST_IDLE;
               end else if (HEX_DIGIT != cur_sel_q) begin
                  cur_sel_d    = HEX_DIGIT;
                  settle_cnt_d = '0;
               end else if (HEX != hex_prev_q) begin
                  settle_cnt_d = '0;
               end else if (settle_cnt_q == SETTLE_LAST) begin
                  // Unmatched patterns still occupy the slot, as nibble 0
                  slot_nib_d[{cur_idx, 2'b00} +: 4] = dec_match ? dec_nibble : 4'h0;
                  slot_dp_d[cur_idx] = ~HEX[7];
                  seen_d[cur_idx]    = 1'b1;
                  err_d              = !dec_match;
                  state_d            = ST_HOLD;
               end else begin
                  settle_cnt_d = settle_cnt_q + 1'b1;
               end
            end
            ST_HOLD: begin
               if (sel_blank) begin
                  state_d = ST_IDLE;
               end else if (HEX_DIGIT != cur_sel_q) begin
                  cur_sel_d    = HEX_DIGIT;
                  settle_cnt_d = '0;
                  state_d      = ST_SETTLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      if (commit) begin
         tmo_cnt_d = '0;
      end else if (tmo_cnt_q != TMO_MAX) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end else begin
         tmo_cnt_d = tmo_cnt_q;
      end
      stall_d = (tmo_cnt_d == TMO_MAX);
   end

   // State and registered outputs; reset discards any partial frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cur_sel_q    <= SEL_BLANK;
         settle_cnt_q <= '0;
         hex_prev_q   <= 8'hFF;
         seen_q       <= 4'h0;
         slot_nib_q   <= 16'h0000;
         slot_dp_q    <= 4'h0;
         value_q      <= 16'h0000;
         dp_q         <= 4'h0;
         valid_q      <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
         tmo_cnt_q    <= '0;
         stall_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_sel_q    <= cur_sel_d;
         settle_cnt_q <= settle_cnt_d;
         hex_prev_q   <= hex_prev_d;
         seen_q       <= seen_d;
         slot_nib_q   <= slot_nib_d;
         slot_dp_q    <= slot_dp_d;
         value_q      <= value_d;
         dp_q         <= dp_d;
         valid_q      <= valid_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
         tmo_cnt_q    <= tmo_cnt_d;
         stall_q      <= stall_d;
      end
   end

   assign value      = value_q;
   assign dp         = dp_q;
   assign valid      = valid_q;
   assign frame_done = frame_done_q;
   assign err        = err_q;
   assign stall      = stall_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 100;
   localparam int NV      = 7;

   typedef struct {
      logic [7:0]  h0;
      logic [7:0]  h1;
      logic [7:0]  h2;
      logic [7:0]  h3;
      int          cyc;
      int          exp_fd;
      logic [15:0] exp_val;
      logic [3:0]  exp_dp;
      int          exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  HEX;
   logic [3:0]  HEX_DIGIT;
   logic [15:0] value;
   logic [3:0]  dp;
   logic        valid;
   logic        frame_done;
   logic        err;
   logic        stall;

   int checks = 0;
   int errors = 0;
   int err_pulses = 0;
   int fd_pulses = 0;
   logic [15:0] prev_val = 16'h0000;
   logic exp_valid = 1'b0;
   vec_t vecs [NV];

   always #5 clk = ~clk;

   seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .HEX        (HEX),
      .HEX_DIGIT  (HEX_DIGIT),
      .value      (value),
      .dp         (dp),
      .valid      (valid),
      .frame_done (frame_done),
      .err        (err),
      .stall      (stall)
   );

   // Pulse counters and the rule that value only moves together with frame_done
   always @(negedge clk) begin
      if (err === 1'b1) err_pulses++;
      if (frame_done === 1'b1) fd_pulses++;
      if (rst_n === 1'b1 && value !== prev_val) begin
         checks++;
         if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL atomic_value: value %h -> %h with frame_done=%b, required 1",
                     prev_val, value, frame_done);
         end
      end
      prev_val = value;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic show(input int d, input logic [7:0] h, input int cyc);
      logic [3:0] one;
      one = 4'b0001;
      HEX_DIGIT = ~(one << d);
      HEX = h;
      repeat (cyc) step();
   endtask

   task automatic blank(input int cyc);
      HEX_DIGIT = 4'hF;
      HEX = 8'hFF;
      repeat (cyc) step();
   endtask

   task automatic scan(input logic [7:0] h0, input logic [7:0] h1,
                       input logic [7:0] h2, input logic [7:0] h3, input int cyc);
      show(0, h0, cyc);
      show(1, h1, cyc);
      show(2, h2, cyc);
      show(3, h3, cyc);
      blank(4);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_value"}, value, 16'h0000);
      check({tag, "_dp"}, dp, 4'h0);
      check({tag, "_valid"}, valid, 1'b0);
      check({tag, "_frame_done"}, frame_done, 1'b0);
      check({tag, "_err"}, err, 1'b0);
      check({tag, "_stall"}, stall, 1'b0);
   endtask

   initial begin
      int e0;
      int f0;

      // h0..h3 are full active-low HEX bytes (bit7 = dp, 1 = off)
      vecs[0] = '{8'hB0, 8'hA4, 8'hF9, 8'hC0, 2, 0, 16'h0000, 4'h0, 0};
      vecs[1] = '{8'hB0, 8'hA4, 8'hF9, 8'hC0, 8, 1, 16'h0123, 4'h0, 0};
      vecs[2] = '{8'hB0, 8'hA4, 8'hFF, 8'hC0, 8, 1, 16'h0023, 4'h0, 1};
      vecs[3] = '{8'h88, 8'h83, 8'hC6, 8'hA1, 8, 1, 16'hDCBA, 4'h0, 0};
      vecs[4] = '{8'h06, 8'h8E, 8'h10, 8'h99, 8, 1, 16'h49FE, 4'b0101, 0};
      vecs[5] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 5, 1, 16'h4321, 4'h0, 0};
      vecs[6] = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 4, 0, 16'h4321, 4'h0, 0};

      rst_n = 1'b0;
      HEX_DIGIT = 4'hF;
      HEX = 8'hFF;
      step();
      step();
      check_all_zero("reset");
      rst_n = 1'b1;
      step();

      // Table-driven full scans
      for (int i = 0; i < NV; i++) begin
         e0 = err_pulses;
         f0 = fd_pulses;
         scan(vecs[i].h0, vecs[i].h1, vecs[i].h2, vecs[i].h3, vecs[i].cyc);
         if (vecs[i].exp_fd != 0) exp_valid = 1'b1;
         check($sformatf("v%0d_frame_done", i), fd_pulses - f0, vecs[i].exp_fd);
         check($sformatf("v%0d_value", i), value, vecs[i].exp_val);
         check($sformatf("v%0d_dp", i), dp, vecs[i].exp_dp);
         check($sformatf("v%0d_err", i), err_pulses - e0, vecs[i].exp_err);
         check($sformatf("v%0d_valid", i), valid, exp_valid);
      end

      // Illegal select mid-frame clears partial capture
      show(0, 8'hB0, 8);
      show(1, 8'hA4, 8);
      e0 = err_pulses;
      HEX_DIGIT = 4'b1100;
      step();
      blank(2);
      check("illegal_err", err_pulses - e0, 1);
      f0 = fd_pulses;
      show(2, 8'hF8, 8);
      show(3, 8'h80, 8);
      blank(4);
      check("illegal_no_frame", fd_pulses - f0, 0);
      e0 = err_pulses;
      f0 = fd_pulses;
      scan(8'h92, 8'h82, 8'hF8, 8'h80, 8);
      check("illegal_rescan_fd", fd_pulses - f0, 1);
      check("illegal_rescan_value", value, 16'h8765);
      check("illegal_rescan_err", err_pulses - e0, 0);

      // Reset after two digits captured
      show(0, 8'hB0, 8);
      show(1, 8'hA4, 8);
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      repeat (3) step();
      check_all_zero("rst_hold");
      rst_n = 1'b1;
      exp_valid = 1'b0;
      f0 = fd_pulses;
      show(2, 8'hF9, 8);
      show(3, 8'hC0, 8);
      blank(4);
      check("rst_partial_fd", fd_pulses - f0, 0);
      check("rst_partial_valid", valid, 1'b0);
      f0 = fd_pulses;
      scan(8'hB0, 8'hA4, 8'hF9, 8'hC0, 8);
      check("rst_rescan_fd", fd_pulses - f0, 1);
      check("rst_rescan_value", value, 16'h0123);

      // Stall after TIMEOUT cycles of blanking, cleared by a commit
      rst_n = 1'b0;
      HEX_DIGIT = 4'hF;
      HEX = 8'hFF;
      step();
      step();
      rst_n = 1'b1;
      repeat (TIMEOUT - 1) step();
      check("stall_before", stall, 1'b0);
      step();
      check("stall_at_timeout", stall, 1'b1);
      repeat (50) step();
      check("stall_saturated", stall, 1'b1);
      f0 = fd_pulses;
      scan(8'h92, 8'h82, 8'hF8, 8'h00, 8);
      check("stall_cleared", stall, 1'b0);
      check("stall_scan_dp", dp, 4'b1000);
      check("stall_scan_value", value, 16'h8765);
      check("stall_scan_fd", fd_pulses - f0, 1);

      // Two-cycle latency from last digit's sample point to frame_done
      show(0, 8'h90, 8);
      show(1, 8'h80, 8);
      show(2, 8'hF8, 8);
      show(3, 8'hC0, SETTLE + 1);
      check("lat_sample_fd", frame_done, 1'b0);
      check("lat_sample_value", value, 16'h8765);
      step();
      check("lat_commit_fd", frame_done, 1'b1);
      check("lat_commit_value", value, 16'h0789);
      step();
      check("lat_pulse_end", frame_done, 1'b0);
      blank(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE, default 4: consecutive cycles a digit select SHALL hold stable before its segments are sampled.
REQ-002 Parameter TIMEOUT, default 1_000_000: cycles without a completed frame before stall is raised.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 HEX  input  8  segment bus, active-low; bit7=dp, bits6:0=g,f,e,d,c,b,a.
REQ-006 HEX_DIGIT  input  4  digit select, active-low one-hot; bit0=rightmost digit.
REQ-007 value  output  16  last committed frame, nibble i = digit i.
REQ-008 dp  output  4  last committed decimal points, 1=lit.
REQ-009 valid  output  1  high once at least one frame has committed.
REQ-010 frame_done  output  1  one-cycle pulse on each commit.
REQ-011 err  output  1  one-cycle pulse on any protocol or pattern error.
REQ-012 stall  output  1  level, high while no commit occurred within TIMEOUT cycles.

Function
REQ-013 Select SHALL be legal only when exactly one HEX_DIGIT bit is 0; 4'b1111 is blanking; any other value is illegal.
REQ-014 FSM states: IDLE, SETTLE, HOLD.
REQ-015 IDLE: on legal select, latch it into cur_sel, clear settle counter, go SETTLE.
REQ-016 SETTLE: counter increments while HEX_DIGIT==cur_sel and HEX unchanged vs previous cycle; any change restarts the count (new legal select -> re-latch, blanking -> IDLE).
REQ-017 SETTLE: when counter reaches SETTLE-1 with inputs still stable, sample HEX into slot cur_sel, set seen[cur_sel], go HOLD.
REQ-018 HOLD: stay while HEX_DIGIT==cur_sel; on blanking go IDLE; on a different legal select behave as IDLE in the same cycle.
REQ-019 Illegal select in any state SHALL pulse err, clear seen, and go IDLE.
REQ-020 Decode table (HEX bits6:0 -> nibble): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F.
REQ-021 Unmatched segment pattern SHALL pulse err, store nibble 0, and still set seen for that slot.
REQ-022 Re-sampling a slot before the frame completes SHALL overwrite it.
REQ-023 When seen becomes 4'b1111, value and dp SHALL update from the slots on the next cycle, frame_done pulses that same cycle, valid sets, seen clears.
REQ-024 Latency: last digit's final stable cycle to frame_done = 2 cycles (sample, commit).
REQ-025 value/dp SHALL never change except on a commit (atomic frame update).
REQ-026 Timeout counter SHALL clear on commit, saturate at TIMEOUT; stall = counter==TIMEOUT; stall drops on the commit cycle.
REQ-027 err and frame_done may pulse in the same cycle.

Reset
REQ-028 rst_n low SHALL immediately force: FSM IDLE, seen=0, slots=0, value=16'h0000, dp=4'h0, valid=0, frame_done=0, err=0, stall=0, counters=0.
REQ-029 Reset mid-frame SHALL discard partial slots; first post-reset commit requires all four digits re-captured.

Structure
REQ-030 Shared package seg_pkg SHALL hold the 16-entry segment table, FSM state typedef, and blanking constant 4'b1111.
REQ-031 Segment-to-nibble lookup SHALL be a sub-module seg_pattern_decode (combinational: 7-bit pattern in, nibble and match flag out).
REQ-032 No other sub-modules; implementation 120-400 lines.

Verification
REQ-033 Scan digits 0..3 with patterns 30,24,79,40 (dp off), 8 cycles each -> value=16'h0123 after frame_done, valid=1, err never high.
REQ-034 Same scan, 2 cycles per digit with SETTLE=4 -> no frame_done, value stays 16'h0000.
REQ-035 Digit 2 shows 7F (unmatched) -> err pulse, committed nibble 2 = 0, frame_done still pulses.
REQ-036 HEX_DIGIT=4'b1100 mid-frame -> err pulse, seen cleared; next full scan of 5,6,7,8 -> value=16'h8765.
REQ-037 rst_n low for 3 cycles after digits 0,1 captured -> all outputs 0; then full scan commits correctly.
REQ-038 Hold blanking for TIMEOUT=100 cycles -> stall=1 at cycle 100; full scan with dp on digit 3 -> stall=0, dp=4'b1000.
